// File: rtl/elevator_call_dispatcher.sv
// Request side of the 4-floor elevator: latches call buttons, picks the next floor with a
// SCAN policy, hands it to the controller with a valid/arrive handshake and runs the door timer.
module elevator_call_dispatcher #(
  parameter int DOOR_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_btn,
  input  logic [1:0] i_cur_floor,
  input  logic       i_arrive,
  output logic [1:0] o_req_floor,
  output logic       o_req_valid,
  output logic       o_door_open,
  output logic       o_dir_up,
  output logic [3:0] o_pending,
  output logic       o_fault
);

  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DOOR,
    S_FAULT
  } state_t;

  state_t            r_state;
  logic [1:0]        r_req_floor;
  logic              r_req_valid;
  logic              r_door_open;
  logic              r_dir_up;
  logic [3:0]        r_pending;
  logic              r_fault;
  logic [DOOR_W-1:0] r_door_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;

  state_t            w_state_nxt;
  logic [1:0]        w_req_floor_nxt;
  logic              w_req_valid_nxt;
  logic              w_door_open_nxt;
  logic              w_dir_up_nxt;
  logic [3:0]        w_pending_nxt;
  logic              w_fault_nxt;
  logic [DOOR_W-1:0] w_door_cnt_nxt;
  logic [TMO_W-1:0]  w_tmo_cnt_nxt;

  logic [3:0]        w_clear;
  logic [3:0]        w_cur_onehot;
  logic [3:0]        w_btn_eff;
  logic              w_accept;
  logic              w_has_above;
  logic              w_has_below;
  logic [1:0]        w_low_above;
  logic [1:0]        w_high_below;

  assign w_cur_onehot = 4'b0001 << i_cur_floor;
  assign w_btn_eff    = i_btn & ~(r_door_open ? w_cur_onehot : 4'b0000);
  assign w_accept     = i_arrive && (i_cur_floor == r_req_floor);

  // Nearest pending floor above and below the car; scan orders make the closest one win.
  always_comb begin
    w_has_above  = 1'b0;
    w_low_above  = 2'd0;
    w_has_below  = 1'b0;
    w_high_below = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i] && (2'(i) > i_cur_floor)) begin
        w_has_above = 1'b1;
        w_low_above = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r_pending[i] && (2'(i) < i_cur_floor)) begin
        w_has_below  = 1'b1;
        w_high_below = 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_floor_nxt = r_req_floor;
    w_req_valid_nxt = r_req_valid;
    w_door_open_nxt = r_door_open;
    w_dir_up_nxt    = r_dir_up;
    w_fault_nxt     = r_fault;
    w_door_cnt_nxt  = r_door_cnt;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_clear         = 4'b0000;

    case (r_state)
      S_IDLE: begin
        if (r_pending != 4'b0000) begin
          if (r_pending[i_cur_floor]) begin
            w_clear[i_cur_floor] = 1'b1;
            w_door_open_nxt      = 1'b1;
            w_state_nxt          = S_DOOR;
          end else begin
            // Keep sweeping while calls remain ahead, otherwise reverse.
            if (r_dir_up) begin
              if (w_has_above) begin
                w_req_floor_nxt = w_low_above;
              end else begin
                w_req_floor_nxt = w_high_below;
                w_dir_up_nxt    = 1'b0;
              end
            end else begin
              if (w_has_below) begin
                w_req_floor_nxt = w_high_below;
              end else begin
                w_req_floor_nxt = w_low_above;
                w_dir_up_nxt    = 1'b1;
              end
            end
            w_req_valid_nxt = 1'b1;
            w_state_nxt     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_accept) begin
          w_clear[r_req_floor] = 1'b1;
          w_req_valid_nxt      = 1'b0;
          w_door_open_nxt      = 1'b1;
          w_state_nxt          = S_DOOR;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_req_valid_nxt = 1'b0;
          w_fault_nxt     = 1'b1;
          w_state_nxt     = S_FAULT;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_DOOR: begin
        if (r_door_cnt == DOOR_LAST) begin
          w_door_open_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_door_cnt_nxt = r_door_cnt + DOOR_W'(1);
        end
      end
      S_FAULT: begin
        w_req_valid_nxt = 1'b0;
        w_door_open_nxt = 1'b0;
        w_fault_nxt     = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_door_cnt_nxt = '0;
      w_tmo_cnt_nxt  = '0;
    end

    // A clear on this edge beats a simultaneous press of the same floor.
    w_pending_nxt = (r_pending | w_btn_eff) & ~w_clear;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req_floor <= 2'd0;
      r_req_valid <= 1'b0;
      r_door_open <= 1'b0;
      r_dir_up    <= 1'b1;
      r_pending   <= 4'b0000;
      r_fault     <= 1'b0;
      r_door_cnt  <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_floor <= w_req_floor_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_door_open <= w_door_open_nxt;
      r_dir_up    <= w_dir_up_nxt;
      r_pending   <= w_pending_nxt;
      r_fault     <= w_fault_nxt;
      r_door_cnt  <= w_door_cnt_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

  assign o_req_floor = r_req_floor;
  assign o_req_valid = r_req_valid;
  assign o_door_open = r_door_open;
  assign o_dir_up    = r_dir_up;
  assign o_pending   = r_pending;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher: reset, handshake, SCAN order, door timer,
// same-floor calls, timeout fault and calls arriving during travel.
module tb_elevator_call_dispatcher;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [1:0] cur_floor;
  logic       arrive;
  logic [1:0] req_floor;
  logic       req_valid;
  logic       door_open;
  logic       dir_up;
  logic [3:0] pending;
  logic       fault;

  int total;
  int bad;

  elevator_call_dispatcher #(
    .DOOR_CYCLES   (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn      (btn),
    .i_cur_floor(cur_floor),
    .i_arrive   (arrive),
    .o_req_floor(req_floor),
    .o_req_valid(req_valid),
    .o_door_open(door_open),
    .o_dir_up   (dir_up),
    .o_pending  (pending),
    .o_fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [1:0] floor);
    rst_n     = 1'b0;
    btn       = 4'b0000;
    arrive    = 1'b0;
    cur_floor = floor;
    steps(2);
    rst_n = 1'b1;
    step();
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  task automatic arrive_at(input logic [1:0] f);
    cur_floor = f;
    arrive    = 1'b1;
    step();
    arrive = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'd0);
    total++;
    if ({req_floor, req_valid, door_open, dir_up, pending, fault} !== {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_values got rf=%0d rv=%b do=%b up=%b pend=%b f=%b", req_floor, req_valid, door_open, dir_up, pending, fault);
    end
    press(4'b0100);
    step();
    total++;
    if (req_valid !== 1'b1 || req_floor !== 2'd2) begin
      bad++;
      $display("[TB] FAIL reset_pre_issue got rv=%b rf=%0d want rv=1 rf=2", req_valid, req_floor);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_floor, req_valid, door_open, dir_up, pending, fault} !== {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_async got rf=%0d rv=%b do=%b up=%b pend=%b f=%b", req_floor, req_valid, door_open, dir_up, pending, fault);
    end
    step();
    rst_n = 1'b1;
    steps(2);
    total++;
    if (req_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_calls_lost got rv=%b pend=%b want rv=0 pend=0000", req_valid, pending);
    end
  endtask

  task automatic test_handshake();
    do_reset(2'd0);
    press(4'b1000);
    total++;
    if (pending !== 4'b1000 || req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hs_latch got pend=%b rv=%b want 1000 0", pending, req_valid);
    end
    step();
    total++;
    if (req_valid !== 1'b1 || req_floor !== 2'd3 || dir_up !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hs_issue got rv=%b rf=%0d up=%b want 1 3 1", req_valid, req_floor, dir_up);
    end
    arrive_at(2'd2);
    total++;
    if (req_valid !== 1'b1 || door_open !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hs_wrong_floor got rv=%b do=%b want 1 0", req_valid, door_open);
    end
    arrive_at(2'd3);
    total++;
    if (req_valid !== 1'b0 || door_open !== 1'b1 || pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL hs_accept got rv=%b do=%b pend=%b want 0 1 0000", req_valid, door_open, pending);
    end
    for (int i = 1; i < 4; i++) begin
      step();
      total++;
      if (door_open !== 1'b1) begin
        bad++;
        $display("[TB] FAIL hs_door_hold cycle %0d got do=%b want 1", i, door_open);
      end
    end
    step();
    total++;
    if (door_open !== 1'b0 || req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hs_door_close got do=%b rv=%b want 0 0", door_open, req_valid);
    end
  endtask

  task automatic test_scan();
    do_reset(2'd1);
    press(4'b1001);
    step();
    total++;
    if (req_floor !== 2'd3 || req_valid !== 1'b1 || dir_up !== 1'b1) begin
      bad++;
      $display("[TB] FAIL scan_first got rf=%0d rv=%b up=%b want 3 1 1", req_floor, req_valid, dir_up);
    end
    arrive_at(2'd3);
    total++;
    if (pending !== 4'b0001 || door_open !== 1'b1) begin
      bad++;
      $display("[TB] FAIL scan_serve3 got pend=%b do=%b want 0001 1", pending, door_open);
    end
    steps(5);
    total++;
    if (req_floor !== 2'd0 || req_valid !== 1'b1 || dir_up !== 1'b0) begin
      bad++;
      $display("[TB] FAIL scan_reverse got rf=%0d rv=%b up=%b want 0 1 0", req_floor, req_valid, dir_up);
    end
    arrive_at(2'd0);
    total++;
    if (pending !== 4'b0000 || door_open !== 1'b1) begin
      bad++;
      $display("[TB] FAIL scan_serve0 got pend=%b do=%b want 0000 1", pending, door_open);
    end
  endtask

  task automatic test_same_floor();
    do_reset(2'd2);
    press(4'b0100);
    step();
    total++;
    if (door_open !== 1'b1 || req_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL same_open got do=%b rv=%b pend=%b want 1 0 0000", door_open, req_valid, pending);
    end
    press(4'b0100);
    total++;
    if (pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL same_drop got pend=%b want 0000", pending);
    end
    steps(3);
    total++;
    if (door_open !== 1'b0 || req_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL same_close got do=%b rv=%b pend=%b want 0 0 0000", door_open, req_valid, pending);
    end
  endtask

  task automatic test_timeout();
    do_reset(2'd0);
    press(4'b0010);
    step();
    steps(63);
    total++;
    if (req_valid !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tmo_before got rv=%b f=%b want 1 0", req_valid, fault);
    end
    step();
    total++;
    if (fault !== 1'b1 || req_valid !== 1'b0 || door_open !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tmo_fault got f=%b rv=%b do=%b want 1 0 0", fault, req_valid, door_open);
    end
    arrive_at(2'd1);
    btn = 4'b1000;
    steps(3);
    btn = 4'b0000;
    total++;
    if (fault !== 1'b1 || req_valid !== 1'b0 || door_open !== 1'b0 || pending !== 4'b1010) begin
      bad++;
      $display("[TB] FAIL tmo_sticky got f=%b rv=%b do=%b pend=%b want 1 0 0 1010", fault, req_valid, door_open, pending);
    end
    do_reset(2'd0);
    press(4'b0010);
    step();
    steps(63);
    arrive_at(2'd1);
    total++;
    if (fault !== 1'b0 || door_open !== 1'b1 || req_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL tmo_last_accept got f=%b do=%b rv=%b pend=%b want 0 1 0 0000", fault, door_open, req_valid, pending);
    end
  endtask

  task automatic test_travel();
    do_reset(2'd0);
    press(4'b1000);
    step();
    press(4'b0110);
    total++;
    if (req_floor !== 2'd3 || req_valid !== 1'b1 || pending !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL travel_hold got rf=%0d rv=%b pend=%b want 3 1 1110", req_floor, req_valid, pending);
    end
    arrive_at(2'd1);
    total++;
    if (req_floor !== 2'd3 || req_valid !== 1'b1 || pending !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL travel_no_retarget got rf=%0d rv=%b pend=%b want 3 1 1110", req_floor, req_valid, pending);
    end
    arrive_at(2'd3);
    steps(5);
    total++;
    if (req_floor !== 2'd2 || req_valid !== 1'b1 || dir_up !== 1'b0 || pending !== 4'b0110) begin
      bad++;
      $display("[TB] FAIL travel_second got rf=%0d rv=%b up=%b pend=%b want 2 1 0 0110", req_floor, req_valid, dir_up, pending);
    end
    btn = 4'b0100;
    arrive_at(2'd2);
    btn = 4'b0000;
    total++;
    if (pending !== 4'b0010 || door_open !== 1'b1) begin
      bad++;
      $display("[TB] FAIL travel_press_served got pend=%b do=%b want 0010 1", pending, door_open);
    end
    steps(5);
    total++;
    if (req_floor !== 2'd1 || req_valid !== 1'b1 || dir_up !== 1'b0) begin
      bad++;
      $display("[TB] FAIL travel_third got rf=%0d rv=%b up=%b want 1 1 0", req_floor, req_valid, dir_up);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    btn       = 4'b0000;
    arrive    = 1'b0;
    cur_floor = 2'd0;
    test_reset();
    test_handshake();
    test_scan();
    test_same_floor();
    test_timeout();
    test_travel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
